// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the ram_fifo_ctrl FIFO front end:
// default widths/depth and the ram wena encoding.
package ram_fifo_ctrl_pkg;

   localparam int P_DATA_W = 32;
   localparam int P_ADDR_W = 5;
   localparam int P_DEPTH  = 2 ** P_ADDR_W;

   localparam logic RAM_WR = 1'b1;
   localparam logic RAM_RD = 1'b0;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping ADDR_W-bit RAM pointer with increment enable and sync clear.
// Ports: clk, rst (async high), i_clr, i_inc, o_ptr.
module ram_fifo_ptr
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int AW = P_ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [AW-1:0] o_ptr
);

   localparam logic [AW-1:0] L_ONE = AW'(1);

   logic [AW-1:0] r_ptr;

   // Natural binary wrap: DEPTH is always 2**AW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= r_ptr + L_ONE;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a single-port 32x32 ram.
// Ports: clk, rst (async high), wr_valid/wr_ready/wr_data push side,
//   rd_valid/rd_ready/rd_data pop side (registered head word),
//   count/full/empty status, ram_ena/ram_wena/ram_addr/ram_wdata to
//   the ram and ram_rdata back (one cycle after a read access).
// Optional: define RAM_FIFO_CLR_EN to add a synchronous clr input.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = P_DATA_W,
   parameter int ADDR_W = P_ADDR_W,
   parameter int DEPTH  = P_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
`ifdef RAM_FIFO_CLR_EN
   input  logic              clr,
`endif
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              ram_ena,
   output logic              ram_wena,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] L_ONE  = (ADDR_W+1)'(1);

   logic [ADDR_W:0]   r_ram_cnt;
   logic              r_rd_pend;
   logic              r_rd_valid;
   logic [DATA_W-1:0] r_rd_data;

   logic [ADDR_W-1:0] w_wr_ptr;
   logic [ADDR_W-1:0] w_rd_ptr;
   logic              w_clr;
   logic              w_full;
   logic              w_rd_want;
   logic              w_rd_issue;
   logic              w_wr_ready;
   logic              w_wr_fire;
   logic              w_pop;

`ifdef RAM_FIFO_CLR_EN
   assign w_clr = clr;
`else
   assign w_clr = 1'b0;
`endif

   assign w_full = (r_ram_cnt == L_FULL);

   // Refill the output register as soon as it and the read slot are
   // free; reads win the single RAM port over writes.
   assign w_rd_want  = (r_ram_cnt != '0) && !r_rd_pend && !r_rd_valid;
   assign w_rd_issue = w_rd_want && !w_clr;
   assign w_wr_ready = !w_full && !w_rd_want && !w_clr;
   assign w_wr_fire  = wr_valid && w_wr_ready;
   assign w_pop      = r_rd_valid && rd_ready && !w_clr;

   ram_fifo_ptr #(.AW(ADDR_W)) u_wr_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_inc (w_wr_fire),
      .o_ptr (w_wr_ptr)
   );

   ram_fifo_ptr #(.AW(ADDR_W)) u_rd_ptr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_inc (w_rd_issue),
      .o_ptr (w_rd_ptr)
   );

   always_comb begin
      ram_ena   = 1'b0;
      ram_wena  = RAM_RD;
      ram_addr  = '0;
      ram_wdata = '0;
      if (w_rd_issue) begin
         ram_ena  = 1'b1;
         ram_wena = RAM_RD;
         ram_addr = w_rd_ptr;
      end else if (w_wr_fire) begin
         ram_ena   = 1'b1;
         ram_wena  = RAM_WR;
         ram_addr  = w_wr_ptr;
         ram_wdata = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_cnt  <= '0;
         r_rd_pend  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else if (w_clr) begin
         r_ram_cnt  <= '0;
         r_rd_pend  <= 1'b0;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_wr_fire) begin
            r_ram_cnt <= r_ram_cnt + L_ONE;
         end else if (w_rd_issue) begin
            r_ram_cnt <= r_ram_cnt - L_ONE;
         end
         r_rd_pend <= w_rd_issue;
         // A pending read never coexists with a valid head word.
         if (r_rd_pend) begin
            r_rd_data  <= ram_rdata;
            r_rd_valid <= 1'b1;
         end else if (w_pop) begin
            r_rd_valid <= 1'b0;
         end
      end
   end

   assign wr_ready = w_wr_ready;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign count    = r_ram_cnt
                   + (ADDR_W+1)'(r_rd_pend)
                   + (ADDR_W+1)'(r_rd_valid);
   assign full     = w_full;
   assign empty    = (count == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural 32x32 ram,
// a vector table for first-word latency and a data scoreboard.
module tb_ram_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
`ifdef RAM_FIFO_CLR_EN
   logic        clr = 1'b0;
`endif
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [31:0] wr_data = '0;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [31:0] rd_data;
   logic [5:0]  count;
   logic        full;
   logic        empty;
   logic        ram_ena;
   logic        ram_wena;
   logic [4:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;

   logic [31:0] mem [32];
   logic [31:0] sb [$];

   int n_tests = 0;
   int n_fail  = 0;

   int m_cnt, m_wptr, m_rptr;
   logic m_pend, m_valid, e_issue, e_wrdy, wf, pp;
   logic saw_wrap = 1'b0;

   ram_fifo_ctrl dut (
      .clk       (clk),
      .rst       (rst),
`ifdef RAM_FIFO_CLR_EN
      .clr       (clr),
`endif
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .ram_ena   (ram_ena),
      .ram_wena  (ram_wena),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_ena) begin
         if (ram_wena) mem[ram_addr] <= ram_wdata;
         else          ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Spec-level reference model and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      logic in_clr;
      in_clr = 1'b0;
`ifdef RAM_FIFO_CLR_EN
      in_clr = clr;
`endif
      if (rst || in_clr) begin
         if (!rst) begin
            chk("clr_ram_ena", 32'(ram_ena), 32'd0);
            chk("clr_wr_ready", 32'(wr_ready), 32'd0);
         end
         m_cnt = 0; m_wptr = 0; m_rptr = 0;
         m_pend = 1'b0; m_valid = 1'b0;
         sb.delete();
      end else begin
         e_issue = (m_cnt != 0) && !m_pend && !m_valid;
         e_wrdy  = (m_cnt != 32) && !e_issue;
         wf = wr_valid && e_wrdy;
         pp = m_valid && rd_ready;
         chk("m_wr_ready", 32'(wr_ready), 32'(e_wrdy));
         chk("m_rd_valid", 32'(rd_valid), 32'(m_valid));
         chk("m_count", 32'(count), 32'(m_cnt + int'(m_pend) + int'(m_valid)));
         chk("m_full", 32'(full), 32'(m_cnt == 32));
         chk("m_ram_ena", 32'(ram_ena), 32'(e_issue || wf));
         if (e_issue) begin
            chk("m_rd_wena", 32'(ram_wena), 32'd0);
            chk("m_rd_addr", 32'(ram_addr), 32'(m_rptr));
         end else if (wf) begin
            chk("m_wr_wena", 32'(ram_wena), 32'd1);
            chk("m_wr_addr", 32'(ram_addr), 32'(m_wptr));
            chk("m_wr_wdata", ram_wdata, wr_data);
         end else begin
            chk("idle_addr", 32'(ram_addr), 32'd0);
            chk("idle_wdata", ram_wdata, 32'd0);
         end
         if (pp) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("sb_data", rd_data, sb.pop_front());
         end
         if (wf) sb.push_back(wr_data);
         if (m_pend) m_valid = 1'b1;
         else if (pp) m_valid = 1'b0;
         m_pend = e_issue;
         m_cnt = m_cnt + int'(wf) - int'(e_issue);
         if (wf && m_wptr == 31) saw_wrap = 1'b1;
         m_wptr = (m_wptr + int'(wf)) % 32;
         m_rptr = (m_rptr + int'(e_issue)) % 32;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_n(input int n, input logic [31:0] base);
      int acc = 0;
      int cyc = 0;
      wr_valid = 1'b1;
      wr_data = base;
      while (acc < n && cyc < 500) begin
         @(negedge clk);
         if (wr_ready) acc++;
         tick();
         wr_data = base + 32'(acc);
         cyc++;
      end
      wr_valid = 1'b0;
      wr_data = '0;
      chk("push_accepted", 32'(acc), 32'(n));
   endtask

   task automatic drain();
      int cyc = 0;
      rd_ready = 1'b1;
      while (cyc < 500) begin
         @(negedge clk);
         if (empty) break;
         tick();
         cyc++;
      end
      tick();
      rd_ready = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);
      chk("drain_sb_left", 32'(sb.size()), 32'd0);
   endtask

   typedef struct {
      logic        wv;
      logic [31:0] wd;
      logic        rr;
      logic [5:0]  cnt;
      logic        wrdy;
      logic        rv;
      logic [31:0] rdat;
      logic        ena;
      logic        wena;
      logic [4:0]  addr;
      logic [31:0] wdat;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{1'b1, 32'h1, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 5'd0, 32'h1};
      tbl[1] = '{1'b0, 32'h0, 1'b0, 6'd1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0};
      tbl[2] = '{1'b0, 32'h0, 1'b0, 6'd1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[3] = '{1'b0, 32'h0, 1'b0, 6'd1, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[4] = '{1'b0, 32'h0, 1'b1, 6'd1, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0, 5'd0, 32'h0};
      tbl[5] = '{1'b0, 32'h0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0};

      // Reset state
      tick();
      tick();
      @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_ram_ena", 32'(ram_ena), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      tick();
      rst = 1'b0;

      // First-word latency, one vector per cycle
      for (int i = 0; i < 6; i++) begin
         wr_valid = tbl[i].wv;
         wr_data  = tbl[i].wd;
         rd_ready = tbl[i].rr;
         @(negedge clk);
         chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].wrdy));
         chk($sformatf("v%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
         if (tbl[i].rv) chk($sformatf("v%0d_rd_data", i), rd_data, tbl[i].rdat);
         chk($sformatf("v%0d_ram_ena", i), 32'(ram_ena), 32'(tbl[i].ena));
         chk($sformatf("v%0d_ram_wena", i), 32'(ram_wena), 32'(tbl[i].wena));
         chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
         chk($sformatf("v%0d_ram_wdata", i), ram_wdata, tbl[i].wdat);
         tick();
      end
      wr_valid = 1'b0;
      rd_ready = 1'b0;

      // Fill to 33 words, then offer a 34th
      push_n(33, 32'h1);
      wr_valid = 1'b1;
      wr_data = 32'h22;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_flag", 32'(full), 32'd1);
         chk("full_count", 32'(count), 32'd33);
         chk("full_wr_ready", 32'(wr_ready), 32'd0);
         chk("full_ram_ena", 32'(ram_ena), 32'd0);
         tick();
      end
      wr_valid = 1'b0;
      chk("full_sb_size", 32'(sb.size()), 32'd33);
      drain();

      // Wrap with occupancy kept at one word
      saw_wrap = 1'b0;
      for (int i = 0; i < 40; i++) begin
         int cyc;
         wr_valid = 1'b1;
         wr_data = 32'h1000 + 32'(i);
         cyc = 0;
         while (cyc < 20) begin
            @(negedge clk);
            if (wr_ready) break;
            tick();
            cyc++;
         end
         tick();
         wr_valid = 1'b0;
         rd_ready = 1'b1;
         cyc = 0;
         while (cyc < 20) begin
            @(negedge clk);
            if (rd_valid) break;
            tick();
            cyc++;
         end
         tick();
         rd_ready = 1'b0;
         if (cyc >= 20) chk("wrap_timeout", 32'(cyc), 32'd0);
      end
      chk("wrap_seen", 32'(saw_wrap), 32'd1);
      chk("wrap_sb_left", 32'(sb.size()), 32'd0);

      // Simultaneous push and pop with 3 words held
      push_n(3, 32'h500);
      repeat (3) tick();
      @(negedge clk);
      chk("sim_pre_count", 32'(count), 32'd3);
      chk("sim_pre_valid", 32'(rd_valid), 32'd1);
      tick();
      wr_valid = 1'b1;
      wr_data = 32'h100;
      rd_ready = 1'b1;
      @(negedge clk);
      chk("sim_wr_ready", 32'(wr_ready), 32'd1);
      tick();
      wr_valid = 1'b0;
      rd_ready = 1'b0;
      @(negedge clk);
      chk("sim_post_count", 32'(count), 32'd3);
      tick();
      drain();

      // Reset with 5 words held
      push_n(5, 32'h700);
      repeat (3) tick();
      @(negedge clk);
      chk("mid_pre_count", 32'(count), 32'd5);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_async_count", 32'(count), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_count", 32'(count), 32'd0);
      chk("mid_empty", 32'(empty), 32'd1);
      chk("mid_rd_valid", 32'(rd_valid), 32'd0);
      chk("mid_ram_ena", 32'(ram_ena), 32'd0);
      tick();
      push_n(2, 32'h900);
      drain();

`ifdef RAM_FIFO_CLR_EN
      // Synchronous clear with a word offered
      push_n(10, 32'h2000);
      repeat (3) tick();
      wr_valid = 1'b1;
      wr_data = 32'hDEAD;
      clr = 1'b1;
      @(negedge clk);
      chk("clr_cyc_ena", 32'(ram_ena), 32'd0);
      tick();
      clr = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk);
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_empty", 32'(empty), 32'd1);
      tick();
      push_n(1, 32'h77);
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
